// File: rtl/regression_error_acc_if.sv
// Handshake and result bundle for regression_error_acc.
// The master drives batch control and sample pairs; the slave returns readiness and results.
interface regression_error_acc_if #(
    parameter int unsigned N_W   = 8,
    parameter int unsigned ACC_W = 48
);
    logic             start;
    logic [N_W-1:0]   n_samples;
    logic [31:0]      thresh;
    logic [31:0]      y_pred;
    logic [31:0]      y_target;
    logic             in_valid;
    logic             in_ready;
    logic             busy;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] sae;
    logic [31:0]      max_abs;
    logic [N_W-1:0]   n_over;

    modport master (
        output start, n_samples, thresh, y_pred, y_target, in_valid, out_ready,
        input  in_ready, busy, out_valid, sae, max_abs, n_over
    );

    modport slave (
        input  start, n_samples, thresh, y_pred, y_target, in_valid, out_ready,
        output in_ready, busy, out_valid, sae, max_abs, n_over
    );
endinterface

// File: rtl/regression_error_acc.sv
// Batch error accumulator: sum of absolute residuals, peak residual and outlier count
// over n_samples prediction/target pairs, presented once per batch.
module regression_error_acc #(
    parameter int unsigned N_W   = 8,
    parameter int unsigned ACC_W = 48
) (
    input  logic                  clk,
    input  logic                  rst_n,
    regression_error_acc_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [N_W-1:0]   n_q, n_d;
    logic [N_W-1:0]   cnt_q, cnt_d;
    logic [31:0]      thresh_q, thresh_d;
    logic [ACC_W-1:0] sae_q, sae_d;
    logic [31:0]      max_q, max_d;
    logic [N_W-1:0]   nover_q, nover_d;

    logic             accept_start;
    logic             xfer;
    logic             last;
    logic [32:0]      diff;
    logic [32:0]      mag;
    logic [31:0]      abs_r;

    assign accept_start = (state_q == StIdle) && bus.start;
    assign xfer         = (state_q == StRun) && bus.in_valid;
    assign last         = (cnt_q == n_q - N_W'(1));

    // 33-bit difference keeps the full signed range; its magnitude always fits in 32 bits.
    assign diff  = {1'b0, bus.y_target} - {1'b0, bus.y_pred};
    assign mag   = diff[32] ? (33'd0 - diff) : diff;
    assign abs_r = mag[31:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = (bus.n_samples == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (xfer && last) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == StRun);
        bus.busy      = (state_q == StRun) || (state_q == StDone);
        bus.out_valid = (state_q == StDone);
        bus.sae       = sae_q;
        bus.max_abs   = max_q;
        bus.n_over    = nover_q;
    end

    always_comb begin
        n_d      = n_q;
        cnt_d    = cnt_q;
        thresh_d = thresh_q;
        sae_d    = sae_q;
        max_d    = max_q;
        nover_d  = nover_q;
        if (accept_start) begin
            n_d      = bus.n_samples;
            thresh_d = bus.thresh;
            cnt_d    = '0;
            sae_d    = '0;
            max_d    = '0;
            nover_d  = '0;
        end else if (xfer) begin
            cnt_d = cnt_q + N_W'(1);
            sae_d = sae_q + ACC_W'(abs_r);
            if (abs_r > max_q) begin
                max_d = abs_r;
            end
            if (abs_r > thresh_q) begin
                nover_d = nover_q + N_W'(1);
            end
        end
    end

    // Results stay in these registers through IDLE until the next accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q      <= '0;
            cnt_q    <= '0;
            thresh_q <= '0;
            sae_q    <= '0;
            max_q    <= '0;
            nover_q  <= '0;
        end else begin
            n_q      <= n_d;
            cnt_q    <= cnt_d;
            thresh_q <= thresh_d;
            sae_q    <= sae_d;
            max_q    <= max_d;
            nover_q  <= nover_d;
        end
    end

endmodule

// File: tb/tb_regression_error_acc.sv
// Directed scoreboard bench for regression_error_acc; expected batch results are computed
// from the driven pairs, queued, and compared when out_valid appears.
module tb_regression_error_acc;

    localparam int unsigned N_W   = 8;
    localparam int unsigned ACC_W = 48;

    typedef struct {
        logic [63:0] sae;
        logic [31:0] mx;
        logic [7:0]  nov;
    } res_t;

    logic clk;
    logic rst_n;
    int   ncmp;
    int   nfail;
    res_t sb[$];

    // Reference model state for the batch being driven.
    logic [63:0] m_sae;
    logic [31:0] m_mx;
    logic [7:0]  m_nov;
    logic [31:0] m_th;
    int          m_n;
    int          m_cnt;

    regression_error_acc_if #(.N_W(N_W), .ACC_W(ACC_W)) bus ();

    regression_error_acc #(.N_W(N_W), .ACC_W(ACC_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_batch(input int n, input logic [31:0] th);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.n_samples = n[7:0];
        bus.thresh    = th;
        m_sae = '0; m_mx = '0; m_nov = '0; m_th = th; m_n = n; m_cnt = 0;
        if (n == 0) begin
            res_t r;
            r.sae = '0; r.mx = '0; r.nov = '0;
            sb.push_back(r);
        end
        @(negedge clk);
        bus.start     = 1'b0;
        bus.n_samples = 8'd77;
        bus.thresh    = 32'hFFFF_FFFF;
    endtask

    task automatic send(input logic [31:0] p, input logic [31:0] t);
        int w;
        logic [31:0] a;
        w = 0;
        while (!bus.in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (w == 20) check("in_ready_timeout", {63'd0, bus.in_ready}, 64'd1);
        bus.y_pred   = p;
        bus.y_target = t;
        bus.in_valid = 1'b1;
        a = (t >= p) ? (t - p) : (p - t);
        m_sae = m_sae + {32'd0, a};
        if (a > m_mx) m_mx = a;
        if (a > m_th) m_nov = m_nov + 8'd1;
        m_cnt++;
        if (m_cnt == m_n) begin
            res_t r;
            r.sae = m_sae; r.mx = m_mx; r.nov = m_nov;
            sb.push_back(r);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic expect_result(input string tag);
        int w;
        res_t r;
        w = 0;
        while (!bus.out_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (w == 20) begin
            check({tag, "_timeout"}, {63'd0, bus.out_valid}, 64'd1);
        end else if (sb.size() == 0) begin
            check({tag, "_unexpected"}, 64'd1, {63'd0, bus.busy});
        end else begin
            r = sb.pop_front();
            check({tag, "_sae"}, {16'd0, bus.sae}, r.sae);
            check({tag, "_max"}, {32'd0, bus.max_abs}, {32'd0, r.mx});
            check({tag, "_nover"}, {56'd0, bus.n_over}, {56'd0, r.nov});
        end
    endtask

    task automatic accept(input string tag);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_ov_low"}, {63'd0, bus.out_valid}, 64'd0);
        check({tag, "_idle"}, {63'd0, bus.busy}, 64'd0);
    endtask

    initial begin
        ncmp = 0; nfail = 0;
        bus.start = 1'b0; bus.n_samples = '0; bus.thresh = '0;
        bus.y_pred = '0; bus.y_target = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_sae", {16'd0, bus.sae}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single sample: first start right after reset release, 1-cycle result latency.
        start_batch(1, 32'd5);
        check("t1_busy", {63'd0, bus.busy}, 64'd1);
        send(32'd510000, 32'd510010);
        check("t1_latency", {63'd0, bus.out_valid}, 64'd1);
        expect_result("t1");
        accept("t1");
        check("t1_held_sae", {16'd0, bus.sae}, 64'd10);

        // Mixed sign residuals.
        start_batch(3, 32'd50);
        send(32'd100, 32'd40);
        send(32'd40, 32'd100);
        send(32'd7, 32'd7);
        check("t2_in_ready_low", {63'd0, bus.in_ready}, 64'd0);
        expect_result("t2");
        accept("t2");

        // Full-range magnitudes with zero threshold.
        start_batch(2, 32'd0);
        send(32'd0, 32'hFFFF_FFFF);
        send(32'hFFFF_FFFF, 32'd0);
        expect_result("t3");
        accept("t3");

        // Input stalls, DONE backpressure, and pairs offered while DONE are ignored.
        start_batch(2, 32'd3);
        send(32'd20, 32'd25);
        for (int i = 0; i < 4; i++) begin
            check("t4_stall_ready", {63'd0, bus.in_ready}, 64'd1);
            @(negedge clk);
        end
        send(32'd9, 32'd8);
        bus.in_valid = 1'b1; bus.y_pred = 32'd0; bus.y_target = 32'd1000;
        for (int i = 0; i < 5; i++) begin
            check("t4_hold_ov", {63'd0, bus.out_valid}, 64'd1);
            check("t4_hold_sae", {16'd0, bus.sae}, 64'd6);
            check("t4_done_ready", {63'd0, bus.in_ready}, 64'd0);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        expect_result("t4");
        accept("t4");

        // Empty batch goes straight to DONE with cleared results.
        start_batch(0, 32'd1);
        check("t5_empty_ov", {63'd0, bus.out_valid}, 64'd1);
        expect_result("t5");
        accept("t5");

        // start during RUN is ignored; latched thresh and n stay in force.
        start_batch(2, 32'd10);
        bus.start = 1'b1; bus.n_samples = 8'd5; bus.thresh = 32'd0;
        send(32'd0, 32'd11);
        bus.start = 1'b0;
        send(32'd0, 32'd4);
        check("t6_done_after_2", {63'd0, bus.out_valid}, 64'd1);
        expect_result("t6");
        accept("t6");

        // Reset mid-batch abandons it; a fresh batch reports only its own sample.
        start_batch(4, 32'd1);
        send(32'd1, 32'd100);
        send(32'd200, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t7_rst_sae", {16'd0, bus.sae}, 64'd0);
        check("t7_rst_max", {32'd0, bus.max_abs}, 64'd0);
        check("t7_rst_busy", {63'd0, bus.busy}, 64'd0);
        check("t7_rst_ready", {63'd0, bus.in_ready}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        start_batch(1, 32'd2);
        send(32'd50, 32'd47);
        expect_result("t7");
        accept("t7");

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
